// File: rtl/pb_carry_pkg.sv
// Shared types and constants for the pre-bitstream carry resolver.
package pb_carry_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    EMIT_PEND,
    EMIT_RUN,
    DONE
  } state_t;

  localparam logic [1:0] PB_NONE = 2'b00;
  localparam logic [1:0] PB_ONE  = 2'b01;
  localparam logic [1:0] PB_TWO  = 2'b10;

  localparam int         CARRY_BIT = 8;
  localparam logic [7:0] BYTE_FF   = 8'hFF;

  // Presence of {word _2, word _1} for one lane; the reserved code 11 reads as two words.
  function automatic logic [1:0] word_mask(input logic [1:0] flag);
    return {flag[1], flag != PB_NONE};
  endfunction

endpackage

// File: rtl/pb_word_selector.sv
// Picks the first present word at or after start_idx and reports whether it is the last one.
module pb_word_selector (
  input  logic [7:0] mask,
  input  logic [3:0] start_idx,
  output logic [2:0] sel_idx,
  output logic       found,
  output logic       last
);

  // Lowest present index >= start_idx, then look for any present index beyond it.
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    last    = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= start_idx)) begin
        sel_idx = 3'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (found && mask[i] && (3'(i) > sel_idx)) last = 1'b0;
    end
  end

endmodule

// File: rtl/pb_carry_resolver.sv
// Resolves carries in the four-lane pre-bitstream and emits the final byte stream in order.
module pb_carry_resolver
  import pb_carry_pkg::*;
#(
  parameter int PB_WIDTH  = 16,
  parameter int RUN_WIDTH = 16,
  parameter int NUM_LANES = 4
) (
  input  logic                general_clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          pb_flag_1,
  input  logic [1:0]          pb_flag_2,
  input  logic [1:0]          pb_flag_3,
  input  logic [1:0]          pb_flag_4,
  input  logic [PB_WIDTH-1:0] pb_1_1,
  input  logic [PB_WIDTH-1:0] pb_1_2,
  input  logic [PB_WIDTH-1:0] pb_2_1,
  input  logic [PB_WIDTH-1:0] pb_2_2,
  input  logic [PB_WIDTH-1:0] pb_3_1,
  input  logic [PB_WIDTH-1:0] pb_3_2,
  input  logic [PB_WIDTH-1:0] pb_4_1,
  input  logic [PB_WIDTH-1:0] pb_4_2,
  input  logic                flush,
  output logic [7:0]          out_byte,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done,
  output logic                err
);

  localparam int NUM_WORDS = 2 * NUM_LANES;
  localparam logic [RUN_WIDTH-1:0] RUN_MAX = {RUN_WIDTH{1'b1}};

  state_t                 state, state_nxt, ret_state;
  logic [CARRY_BIT:0]     word_in  [NUM_WORDS];
  logic [CARRY_BIT:0]     words_p0 [NUM_WORDS];
  logic [NUM_WORDS-1:0]   mask_p0;
  logic [3:0]             idx;
  logic [2:0]             sel_idx;
  logic                   found, last;
  logic                   has_pending, flush_latched;
  logic [7:0]             pending, emit_byte, fill_byte;
  logic [RUN_WIDTH-1:0]   run;
  logic                   c;
  logic [7:0]             b;
  logic                   handshake;
  logic                   unused_hi;

  // Only carry and byte bits of each word matter; upper bits are dropped on entry.
  assign word_in[0] = pb_1_1[CARRY_BIT:0];
  assign word_in[1] = pb_1_2[CARRY_BIT:0];
  assign word_in[2] = pb_2_1[CARRY_BIT:0];
  assign word_in[3] = pb_2_2[CARRY_BIT:0];
  assign word_in[4] = pb_3_1[CARRY_BIT:0];
  assign word_in[5] = pb_3_2[CARRY_BIT:0];
  assign word_in[6] = pb_4_1[CARRY_BIT:0];
  assign word_in[7] = pb_4_2[CARRY_BIT:0];
  assign unused_hi  = ^{pb_1_1[PB_WIDTH-1:CARRY_BIT+1], pb_1_2[PB_WIDTH-1:CARRY_BIT+1],
                        pb_2_1[PB_WIDTH-1:CARRY_BIT+1], pb_2_2[PB_WIDTH-1:CARRY_BIT+1],
                        pb_3_1[PB_WIDTH-1:CARRY_BIT+1], pb_3_2[PB_WIDTH-1:CARRY_BIT+1],
                        pb_4_1[PB_WIDTH-1:CARRY_BIT+1], pb_4_2[PB_WIDTH-1:CARRY_BIT+1]};

  pb_word_selector u_sel (
    .mask      (mask_p0),
    .start_idx (idx),
    .sel_idx   (sel_idx),
    .found     (found),
    .last      (last)
  );

  assign c         = words_p0[sel_idx][CARRY_BIT];
  assign b         = words_p0[sel_idx][7:0];
  assign handshake = in_valid && in_ready;

  function automatic logic run_saturated(input logic [RUN_WIDTH-1:0] r);
    return r == RUN_MAX;
  endfunction

  // State register.
  always_ff @(posedge general_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and output drive; a carry or a non-FF byte forces emission.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset)  state_nxt = SCAN;
        else if (flush_latched)  state_nxt = has_pending ? EMIT_PEND : DONE;
      end
      SCAN: begin
        if (!found)                                      state_nxt = IDLE;
        else if (has_pending && (c || (b != BYTE_FF)))   state_nxt = EMIT_PEND;
        else if (last)                                   state_nxt = IDLE;
      end
      EMIT_PEND: begin
        out_valid = 1'b1;
        out_byte  = emit_byte;
        if (out_ready) state_nxt = (run != '0) ? EMIT_RUN : ret_state;
      end
      EMIT_RUN: begin
        out_valid = 1'b1;
        out_byte  = fill_byte;
        if (out_ready && (run == RUN_WIDTH'(1))) state_nxt = ret_state;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input group capture (data only).
  always_ff @(posedge general_clk) begin
    if ((state == IDLE) && handshake) begin
      for (int k = 0; k < NUM_WORDS; k++) words_p0[k] <= word_in[k];
    end
  end

  // Pending byte, 0xFF run, emit register, flush latch and sticky error.
  always_ff @(posedge general_clk) begin
    if (reset) begin
      mask_p0       <= '0;
      idx           <= '0;
      has_pending   <= 1'b0;
      pending       <= '0;
      run           <= '0;
      emit_byte     <= '0;
      fill_byte     <= '0;
      ret_state     <= IDLE;
      flush_latched <= 1'b0;
      err           <= 1'b0;
    end else begin
      flush_latched <= flush_latched | flush;
      case (state)
        IDLE: begin
          if (handshake) begin
            mask_p0 <= {word_mask(pb_flag_4), word_mask(pb_flag_3),
                        word_mask(pb_flag_2), word_mask(pb_flag_1)};
            idx     <= '0;
            if ((pb_flag_1 == 2'b11) || (pb_flag_2 == 2'b11) ||
                (pb_flag_3 == 2'b11) || (pb_flag_4 == 2'b11)) err <= 1'b1;
          end else if (flush_latched && has_pending) begin
            emit_byte <= pending;
            fill_byte <= BYTE_FF;
            ret_state <= DONE;
          end
        end
        SCAN: begin
          if (found) begin
            idx <= {1'b0, sel_idx} + 4'd1;
            if (!has_pending) begin
              pending     <= b;
              has_pending <= 1'b1;
              if (c) err <= 1'b1;
            end else if (c) begin
              emit_byte <= pending + 8'd1;
              if (pending == BYTE_FF) err <= 1'b1;
              fill_byte <= 8'h00;
              pending   <= b;
              ret_state <= last ? IDLE : SCAN;
            end else if (b == BYTE_FF) begin
              if (run_saturated(run)) err <= 1'b1;
              else                    run <= run + 1'b1;
            end else begin
              emit_byte <= pending;
              fill_byte <= BYTE_FF;
              pending   <= b;
              ret_state <= last ? IDLE : SCAN;
            end
          end
        end
        EMIT_RUN: begin
          if (out_ready) run <= run - 1'b1;
        end
        DONE: begin
          has_pending   <= 1'b0;
          run           <= '0;
          flush_latched <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pb_carry_resolver.md
Name: pb_carry_resolver

Overview:
Consumes the four-lane pre-bitstream output of the 4-bool arithmetic encoder (PB_FLAG_n, PB_n_1, PB_n_2 per lane) and resolves carries. It emits the final in-order AV1 byte stream, one byte per cycle, with valid/ready handshakes on both sides. It holds the last unresolved byte plus a run of 0xFF bytes until a later word proves them final, or a carry increments them.

Parameters:
PB_WIDTH, 16, width of each pre-bitstream word
RUN_WIDTH, 16, width of the pending 0xFF run counter
NUM_LANES, 4, lanes per input group, fixed at 4

Ports:
general_clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  input group present
in_ready  out  1  group accepted when in_valid && in_ready
pb_flag_1..pb_flag_4  in  2 each  per-lane word count: 00 none, 01 word _1 only, 10 words _1 then _2, 11 reserved
pb_1_1,pb_1_2 .. pb_4_1,pb_4_2  in  PB_WIDTH each  pre-bitstream words; bit 8 = carry, bits 7:0 = byte, bits 15:9 ignored
flush  in  1  end-of-stream request; level, sampled every cycle
out_byte  out  8  resolved byte
out_valid  out  1  out_byte valid
out_ready  in  1  downstream accepts when out_valid && out_ready
done  out  1  one-cycle pulse after the flush drain completes
err  out  1  sticky protocol/overflow error

Behaviour:
- Reset values: in_ready=0 during reset, then 1; out_valid=0, out_byte=0, done=0, err=0. Internal state: has_pending=0, pending=0, run=0, flush_latched=0, FSM=IDLE.
- Reset mid-operation discards the captured group, pending byte and run. No partial bytes are emitted after reset.
- FSM states: IDLE, SCAN, EMIT_PEND, EMIT_RUN, DONE.
- IDLE:
  - in_ready=1.
  - On handshake, register all 8 words and 4 flags, then go to SCAN.
  - If flush_latched and no handshake: go to EMIT_PEND if has_pending, else DONE.
- flush is latched into flush_latched in any state. It is acted on only in IDLE, after the current group fully drains.
- SCAN processes one present word per cycle, in order lane1 w1, lane1 w2, lane2 w1 … lane4 w2. Absent words are skipped at zero cost.
  - Flag 11 behaves as 10 and sets err.
  - A group with all flags 00 returns to IDLE the next cycle.
- Per-word rule, with c = w[8] and b = w[7:0]:
  - !has_pending: pending=b, has_pending=1. If c, set err.
  - c: pending = pending+1 (wraps 8-bit; set err if pending was 0xFF). Run bytes resolve to 0x00. Emit resolved bytes, then pending=b.
  - !c && b==0xFF: run=run+1. No emission. If run saturates at 2^RUN_WIDTH-1, set err and hold.
  - !c && b!=0xFF: emit pending, then run × 0xFF, then pending=b.
- Emission sequence:
  - SCAN goes to EMIT_PEND, which presents the resolved pending byte.
  - Then EMIT_RUN presents the run fill byte (0x00 after carry, 0xFF otherwise), decrementing run each accepted byte.
  - Then return to SCAN at the next word, or to IDLE if it was the last word.
  - If run=0, EMIT_RUN is skipped.
  - The new pending=b is committed when emission starts. The resolved byte and fill value are held in a separate emit register.
- Output handshake:
  - out_byte is stable and out_valid stays high until out_ready.
  - One byte is accepted per cycle at most; there are no bubbles while out_ready=1.
- Latency: the first emitted byte appears one cycle after the SCAN cycle of the resolving word.
- Flush drain: emit pending (if has_pending) then run × 0xFF, then DONE. DONE pulses done=1 for one cycle, clears has_pending, run and flush_latched, then returns to IDLE.
- Flush with empty state (no pending, run=0): DONE is reached directly, with a done pulse 1 cycle after IDLE sees flush_latched.
- Throughput: at most 1 word/cycle in SCAN. Upstream stalls via in_ready=0 in all non-IDLE states.

Decomposition:
- Package pb_carry_pkg holds:
  - FSM state enum
  - PB flag encodings (PB_NONE=2'b00, PB_ONE=2'b01, PB_TWO=2'b10)
  - CARRY_BIT=8
  - BYTE_FF=8'hFF
- One combinational sub-module, pb_word_selector: given the 8-bit word-present mask and the current index, returns the next present index plus a last flag.

Test Plan:
1. Lane1 flag 01, word 0x0012, others 00; then flush → out 0x12, done pulse, err=0.
2. One group: words 0x0010, 0x00FF, 0x00FF, 0x0020; then flush → 10 FF FF 20.
3. Words 0x0010, 0x00FF, 0x00FF, then 0x0120 (carry); then flush → 11 00 00 20.
4. Same as test 2, with out_ready held low for 5 cycles during EMIT_RUN → out_byte holds 0xFF stable, no byte lost or duplicated, in_ready=0 throughout.
5. First word 0x0105 (carry, no pending), and a flag=11 group → err rises and stays 1 until reset.
6. Reset asserted mid EMIT_RUN with run=3 → out_valid=0 the next cycle; a following flush yields only done, with no bytes.
